// File: rtl/res_pkg.sv
// Shared widths, encodings and the address helper for the result drain path.
package res_pkg;

    localparam int ROW_W      = 512;
    localparam int BANK_W     = 128;
    localparam int ADDR_W     = 15;
    localparam int CNT_W      = 11;
    localparam int ADDR_SHIFT = 4;
    localparam int NUM_BANKS  = 8;
    localparam int GRP_BANKS  = 4;

    // Which half of the ping/pong bank set is being drained.
    typedef enum logic {
        GRP_PING = 1'b0,
        GRP_PONG = 1'b1
    } grp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Row index to bank word address: each row sits on a 16-word stride.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [CNT_W-1:0] row);
        return {row, {ADDR_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/res_drain_fifo.sv
// First-word fall-through FIFO with occupancy count; the head is zero while empty.
module res_drain_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_F = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_F-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_F-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // An empty FIFO never pops and a full one only accepts when it also pops.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_F'(DEPTH)) || do_pop);

    // Storage, pointer and count updates for the next cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_F'(1);
            2'b01:   count_d = count_q - CNT_F'(1);
            default: count_d = count_q;
        endcase
    end

    // Register stage with synchronous clear of contents and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/res_drain.sv
// Reads a completed ping or pong half row by row and streams 512-bit rows out.
module res_drain
    import res_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bank_sel,
    input  logic [CNT_W:0]    row_count,
    output logic              busy,
    output logic              done,
    output logic              rce0, rce1, rce2, rce3, rce4, rce5, rce6, rce7,
    output logic [ADDR_W-1:0] raddr0, raddr1, raddr2, raddr3,
    output logic [ADDR_W-1:0] raddr4, raddr5, raddr6, raddr7,
    input  logic [BANK_W-1:0] rdata0, rdata1, rdata2, rdata3,
    input  logic [BANK_W-1:0] rdata4, rdata5, rdata6, rdata7,
    output logic [ROW_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    state_e                         state_q, state_d;
    grp_e                           grp_q, grp_d;
    logic [CNT_W:0]                 row_count_q, row_count_d;
    logic [CNT_W-1:0]               iss_cnt_q, iss_cnt_d;
    logic [CNT_W:0]                 acc_cnt_q, acc_cnt_d;
    logic [NUM_BANKS-1:0]           rce_q, rce_d;
    logic [NUM_BANKS-1:0][ADDR_W-1:0] raddr_q, raddr_d;
    logic [RD_LAT-1:0]              vld_q, vld_d;
    logic [OCC_W-1:0]               inflight_q, inflight_d;

    logic             issue, last_issue, credit_ok, push, pop;
    logic [FC_W-1:0]  fifo_count;
    logic [OCC_W-1:0] occ;
    logic [ROW_W-1:0] push_data;

    // A return is due when the oldest valid-pipe stage fires; pop is the output handshake.
    assign push = vld_q[RD_LAT-1];
    assign pop  = out_valid && out_ready;

    // Every row already owed to the FIFO counts against its free space.
    assign occ        = OCC_W'(fifo_count) + inflight_q;
    assign credit_ok  = (occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);
    assign last_issue = ({1'b0, iss_cnt_q} == (row_count_q - (CNT_W+1)'(1)));

    assign push_data = (grp_q == GRP_PONG) ? {rdata7, rdata6, rdata5, rdata4}
                                           : {rdata3, rdata2, rdata1, rdata0};

    // Next-state logic of the drain sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (row_count == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && last_issue) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (acc_cnt_d == row_count_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and the per-cycle read issue decision.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            ST_ISSUE: begin
                busy  = 1'b1;
                issue = credit_ok;
            end
            ST_WAIT: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Counters, parameter latches, SRAM port muxing and the return-tag pipe.
    always_comb begin
        grp_d       = grp_q;
        row_count_d = row_count_q;
        iss_cnt_d   = iss_cnt_q;
        acc_cnt_d   = acc_cnt_q + (CNT_W+1)'(pop);
        rce_d       = '0;
        raddr_d     = raddr_q;
        if ((state_q == ST_IDLE) && start) begin
            grp_d       = grp_e'(bank_sel);
            row_count_d = row_count;
            iss_cnt_d   = '0;
            acc_cnt_d   = '0;
        end
        if (issue) begin
            iss_cnt_d = iss_cnt_q + CNT_W'(1);
            for (int b = 0; b < GRP_BANKS; b++) begin
                if (grp_q == GRP_PONG) begin
                    rce_d[b + GRP_BANKS]   = 1'b1;
                    raddr_d[b + GRP_BANKS] = row_addr(iss_cnt_q);
                end else begin
                    rce_d[b]   = 1'b1;
                    raddr_d[b] = row_addr(iss_cnt_q);
                end
            end
        end
        vld_d[0] = |rce_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        inflight_d = inflight_q + OCC_W'(issue) - OCC_W'(push);
    end

    // State register; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grp_q       <= GRP_PING;
            row_count_q <= '0;
            iss_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            rce_q       <= '0;
            raddr_q     <= '0;
            vld_q       <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            row_count_q <= row_count_d;
            iss_cnt_q   <= iss_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            rce_q       <= rce_d;
            raddr_q     <= raddr_d;
            vld_q       <= vld_d;
            inflight_q  <= inflight_d;
        end
    end

    res_drain_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_data  (out_data),
        .head_valid (out_valid),
        .count      (fifo_count)
    );

    assign {rce7, rce6, rce5, rce4, rce3, rce2, rce1, rce0} = rce_q;
    assign raddr0 = raddr_q[0];
    assign raddr1 = raddr_q[1];
    assign raddr2 = raddr_q[2];
    assign raddr3 = raddr_q[3];
    assign raddr4 = raddr_q[4];
    assign raddr5 = raddr_q[5];
    assign raddr6 = raddr_q[6];
    assign raddr7 = raddr_q[7];

endmodule

// File: tb/tb_res_drain.sv
// Directed bench for res_drain: table of drain scenarios plus reset sequences.
module tb_res_drain;

    logic         clk;
    logic         rst;
    logic         start;
    logic         bank_sel;
    logic [11:0]  row_count;
    logic         busy, done;
    logic [7:0]   rce_v;
    logic [14:0]  raddr [8];
    logic [127:0] rdata [8];
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run_id   = 0;
    logic exp_grp = 1'b0;

    res_drain #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .row_count(row_count),
        .busy(busy), .done(done),
        .rce0(rce_v[0]), .rce1(rce_v[1]), .rce2(rce_v[2]), .rce3(rce_v[3]),
        .rce4(rce_v[4]), .rce5(rce_v[5]), .rce6(rce_v[6]), .rce7(rce_v[7]),
        .raddr0(raddr[0]), .raddr1(raddr[1]), .raddr2(raddr[2]), .raddr3(raddr[3]),
        .raddr4(raddr[4]), .raddr5(raddr[5]), .raddr6(raddr[6]), .raddr7(raddr[7]),
        .rdata0(rdata[0]), .rdata1(rdata[1]), .rdata2(rdata[2]), .rdata3(rdata[3]),
        .rdata4(rdata[4]), .rdata5(rdata[5]), .rdata6(rdata[6]), .rdata7(rdata[7]),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Free-running clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bank word contents as a function of bank number and address.
    function automatic logic [127:0] memWord(input int bank, input logic [14:0] addr);
        return {16'(16'hB000 + bank), 1'b0, addr, ({17'd0, addr} ^ 32'h0001_2345),
                32'(bank * 7 + 3), (32'hC0DE_0000 + {17'd0, addr})};
    endfunction

    // Expected 512-bit row: bank0 of the group in the low 128 bits.
    function automatic logic [511:0] expRow(input logic grp, input int r);
        logic [511:0] row;
        logic [14:0]  a;
        a = 15'(r * 16);
        for (int b = 0; b < 4; b++) begin
            row[128*b +: 128] = memWord(4 * int'(grp) + b, a);
        end
        return row;
    endfunction

    // Single-cycle-latency SRAM model for all eight banks.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (rce_v[k]) rdata[k] <= memWord(k, raddr[k]);
        end
    end

    // Observation counters, cleared whenever a new run begins.
    int   run_seen = -1;
    int   m_rce, m_hs, m_done, m_valid_cyc, m_gaps, m_addr_err, m_grp_err, m_data_err;
    int   m_stable_err, m_max_out, m_busy_err, m_stall_cyc;
    int   m_first_rce_cyc, m_first_valid_cyc, m_last_hs_cyc, m_done_cyc;
    logic [14:0]  m_last_addr;
    logic         m_prev_valid, m_prev_stall, m_seen_valid;
    logic [511:0] m_prev_data;

    always @(negedge clk) begin
        logic [7:0]  sel;
        logic [14:0] exp_a;
        int          outst;
        if (run_seen != run_id) begin
            run_seen = run_id;
            m_rce = 0; m_hs = 0; m_done = 0; m_valid_cyc = 0; m_gaps = 0;
            m_addr_err = 0; m_grp_err = 0; m_data_err = 0; m_stable_err = 0;
            m_max_out = 0; m_busy_err = 0; m_stall_cyc = 0;
            m_first_rce_cyc = 0; m_first_valid_cyc = 0; m_last_hs_cyc = 0; m_done_cyc = 0;
            m_last_addr = '0; m_prev_valid = 1'b0; m_prev_stall = 1'b0; m_seen_valid = 1'b0;
            m_prev_data = '0;
        end
        if (!rst) begin
            if (rce_v != 8'h00) begin
                sel   = exp_grp ? 8'hF0 : 8'h0F;
                exp_a = 15'(m_rce * 16);
                if (rce_v != sel) m_grp_err++;
                for (int b = 0; b < 4; b++) begin
                    if (raddr[4 * int'(exp_grp) + b] != exp_a) m_addr_err++;
                end
                m_last_addr = raddr[4 * int'(exp_grp)];
                if (m_rce == 0) m_first_rce_cyc = cyc;
                m_rce++;
            end
            outst = m_rce - m_hs;
            if (outst > m_max_out) m_max_out = outst;
            if (m_prev_stall && (!out_valid || out_data != m_prev_data)) m_stable_err++;
            if (out_valid) begin
                if (!m_seen_valid) m_first_valid_cyc = cyc;
                else if (!m_prev_valid) m_gaps++;
                m_seen_valid = 1'b1;
                m_valid_cyc++;
            end
            if (out_valid && out_ready) begin
                if (out_data != expRow(exp_grp, m_hs)) m_data_err++;
                m_hs++;
                m_last_hs_cyc = cyc;
            end
            if (out_valid && !out_ready) m_stall_cyc++;
            m_prev_stall = out_valid && !out_ready;
            m_prev_data  = out_data;
            m_prev_valid = out_valid;
            if (done) begin
                m_done++;
                m_done_cyc = cyc;
                if (busy) m_busy_err++;
            end
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic bank_sel;
        int   rows;
        int   stall_from;
        int   stall_to;
        int   mid_start;
        int   exp_last_addr;
        int   exp_max_out;
        int   exp_stall;
        int   exp_first_lat;
        int   exp_done_lat;
    } vec_t;

    // Drives one start, steers out_ready per cycle and checks the run's totals.
    task automatic applyStimulus(input vec_t v, input string tag);
        int start_cyc;
        int rel;
        int budget;
        int timed_out;
        timed_out = 0;
        budget    = v.rows * 3 + 60;
        @(posedge clk); #1;
        run_id++;
        exp_grp   = v.bank_sel;
        start_cyc = cyc;
        start     = 1'b1;
        bank_sel  = v.bank_sel;
        row_count = 12'(v.rows);
        out_ready = !(0 >= v.stall_from && 0 <= v.stall_to);
        forever begin
            @(posedge clk); #1;
            rel = cyc - start_cyc;
            if (rel == v.mid_start) begin
                start     = 1'b1;
                bank_sel  = !v.bank_sel;
                row_count = 12'd3;
            end else begin
                start     = 1'b0;
                bank_sel  = v.bank_sel;
                row_count = 12'(v.rows);
            end
            out_ready = !(rel >= v.stall_from && rel <= v.stall_to);
            if (m_done > 0 && (cyc - m_done_cyc) >= 4) break;
            if (rel > budget) begin
                timed_out = 1;
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput({tag, "_timeout"}, timed_out, 0);
        checkOutput({tag, "_reads"}, m_rce, v.rows);
        checkOutput({tag, "_handshakes"}, m_hs, v.rows);
        checkOutput({tag, "_data_err"}, m_data_err, 0);
        checkOutput({tag, "_group_err"}, m_grp_err, 0);
        checkOutput({tag, "_addr_err"}, m_addr_err, 0);
        checkOutput({tag, "_done_pulses"}, m_done, 1);
        checkOutput({tag, "_busy_in_done"}, m_busy_err, 0);
        checkOutput({tag, "_gaps"}, m_gaps, 0);
        checkOutput({tag, "_stall_cycles"}, m_stall_cyc, v.exp_stall);
        checkOutput({tag, "_stable_err"}, m_stable_err, 0);
        checkOutput({tag, "_max_outstanding"}, m_max_out, v.exp_max_out);
        if (v.rows > 0) begin
            checkOutput({tag, "_last_addr"}, m_last_addr, v.exp_last_addr);
            checkOutput({tag, "_first_valid_lat"}, m_first_valid_cyc - m_first_rce_cyc, v.exp_first_lat);
            checkOutput({tag, "_done_lat"}, m_done_cyc - m_last_hs_cyc, v.exp_done_lat);
        end else begin
            checkOutput({tag, "_done_lat"}, m_done_cyc - start_cyc, v.exp_done_lat);
        end
    endtask

    // Every output the reset clears, checked while the clock is away from its edge.
    task automatic checkResetOutputs(input string tag);
        logic any_addr;
        any_addr = 1'b0;
        for (int k = 0; k < 8; k++) any_addr = any_addr | (|raddr[k]);
        checkOutput({tag, "_ctrl"}, {busy, done, out_valid, rce_v}, 0);
        checkOutput({tag, "_raddr"}, any_addr, 0);
        checkOutput({tag, "_out_data"}, |out_data, 0);
    endtask

    vec_t tests [6];

    initial begin
        // One row; 16-row pong stream with an ignored start; back-pressure; zero rows;
        // full 2048-row range; short pong run stalled from the start.
        // done follows the last handshake by one cycle, and an empty drain goes
        // straight from IDLE to DONE so done shows in the cycle after start is taken.
        tests[0] = '{1'b0, 1,    -1, -1, -1, 'h0000, 1, 0, 2, 1};
        tests[1] = '{1'b1, 16,   -1, -1,  5, 'h00F0, 3, 0, 2, 1};
        tests[2] = '{1'b0, 8,     3, 10, -1, 'h0070, 4, 7, 2, 1};
        tests[3] = '{1'b1, 0,    -1, -1, -1, 'h0000, 0, 0, 2, 1};
        tests[4] = '{1'b0, 2048, -1, -1, -1, 'h7FF0, 3, 0, 2, 1};
        tests[5] = '{1'b1, 3,     0,  6, -1, 'h0020, 3, 3, 2, 1};

        rst       = 1'b1;
        start     = 1'b0;
        bank_sel  = 1'b0;
        row_count = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tests[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a ten-row drain, once five rows have been taken.
        begin
            int waited;
            waited = 0;
            @(posedge clk); #1;
            run_id++;
            exp_grp   = 1'b0;
            start     = 1'b1;
            bank_sel  = 1'b0;
            row_count = 12'd10;
            @(posedge clk); #1;
            start = 1'b0;
            while (m_hs < 5 && waited < 100) begin
                @(posedge clk); #1;
                waited++;
            end
            checkOutput("midrst_reach_row5", m_hs, 5);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            run_id++;
            @(negedge clk);
            checkResetOutputs("midrst");
            repeat (20) @(posedge clk);
            #1;
            checkOutput("midrst_late_valid", m_valid_cyc, 0);
            checkOutput("midrst_late_done", m_done, 0);
            checkOutput("midrst_late_reads", m_rce, 0);
        end

        applyStimulus('{1'b0, 10, -1, -1, -1, 'h0090, 3, 0, 2, 1}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
